// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo responder.
// Parity encodings, FSM states and the parity rule.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_LOAD       = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } echo_state_t;

   // Odd: total ones over data+bit must be odd.
   // Even: must be even. 00/11 accept everything.
   function automatic logic parity_ok(
      input logic [1:0] ptype,
      input logic [7:0] data,
      input logic       pbit
   );
      logic w_x;
      w_x = ^{data, pbit};
      if (ptype == PAR_ODD) begin
         return w_x;
      end else if (ptype == PAR_EVEN) begin
         return ~w_x;
      end else begin
         return 1'b1;
      end
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO with occupancy count.
// Push into a full FIFO is only honoured with a same-cycle pop.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [7:0]        i_din,
   input  logic              i_pop,
   output logic [7:0]        o_head,
   output logic              o_full,
   output logic              o_empty,
   output logic [ADDR_W:0]   o_count
);

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr;
   logic [ADDR_W-1:0] r_rd;
   logic [ADDR_W:0]   r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_count == (ADDR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;

   // Storage write; contents need no reset
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr] <= i_din;
      end
   end

   // Pointers wrap mod DEPTH; count tracks push/pop
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_echo_responder.sv
// Far-end echo: captures RX bytes, checks parity, queues
// good bytes and relaunches them through the TX block.
module uart_echo_responder
   import uart_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3,
   parameter int TIMEOUT = 200000,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        parity_type,
   input  logic [7:0]        rx_data,
   input  logic              rx_parity_bit,
   input  logic              rx_recieve_flag,
   input  logic              tx_sending,
   output logic              tx_enable,
   output logic [7:0]        tx_din,
   output logic [ADDR_W:0]   fifo_count,
   output logic [CNT_W-1:0]  overflow_cnt,
   output logic [CNT_W-1:0]  parity_err_cnt,
   output logic [CNT_W-1:0]  timeout_cnt,
   output logic              busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   echo_state_t      r_state;
   logic             r_flag_d;
   logic             r_loaded;
   logic             r_tx_en;
   logic [7:0]       r_tx_din;
   logic [TW-1:0]    r_wait;
   logic [CNT_W-1:0] r_ovf;
   logic [CNT_W-1:0] r_perr;
   logic [CNT_W-1:0] r_to;

   logic             w_capture;
   logic             w_par_good;
   logic             w_pop;
   logic             w_push;
   logic             w_ovf;
   logic             w_perr;
   logic             w_full;
   logic             w_empty;
   logic [7:0]       w_head;
   logic [ADDR_W:0]  w_count;

   assign w_capture  = rx_recieve_flag & ~r_flag_d;
   assign w_par_good = parity_ok(parity_type, rx_data,
                                 rx_parity_bit);
   assign w_pop      = (r_state == ST_WAIT_START)
                     & tx_sending & ~w_empty;
   assign w_push     = w_capture & w_par_good
                     & (~w_full | w_pop);
   assign w_ovf      = w_capture & w_par_good
                     & w_full & ~w_pop;
   assign w_perr     = w_capture & ~w_par_good;

   uart_byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_din   (rx_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Flag history; resets high so a held flag is not a new byte
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_flag_d <= 1'b1;
      end else begin
         r_flag_d <= rx_recieve_flag;
      end
   end

   // Saturating counts of dropped bytes
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ovf  <= '0;
         r_perr <= '0;
      end else begin
         if (w_ovf && (r_ovf != '1)) begin
            r_ovf <= r_ovf + 1'b1;
         end
         if (w_perr && (r_perr != '1)) begin
            r_perr <= r_perr + 1'b1;
         end
      end
   end

   // Launch FSM: load byte, request TX, wait start/finish
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_loaded <= 1'b0;
         r_tx_en  <= 1'b0;
         r_tx_din <= '0;
         r_wait   <= '0;
         r_to     <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (!w_empty && !tx_sending) begin
                  r_loaded <= 1'b0;
                  r_state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (!r_loaded) begin
                  r_tx_din <= w_head;
                  r_loaded <= 1'b1;
               end else begin
                  r_tx_en  <= 1'b1;
                  r_wait   <= '0;
                  r_state  <= ST_WAIT_START;
               end
            end
            ST_WAIT_START: begin
               if (tx_sending) begin
                  r_tx_en <= 1'b0;
                  r_state <= ST_WAIT_DONE;
               end else if (r_wait == TW'(TIMEOUT - 1)) begin
                  r_tx_en <= 1'b0;
                  if (r_to != '1) begin
                     r_to <= r_to + 1'b1;
                  end
                  r_state <= ST_IDLE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_sending) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_enable      = r_tx_en;
   assign tx_din         = r_tx_din;
   assign fifo_count     = w_count;
   assign overflow_cnt   = r_ovf;
   assign parity_err_cnt = r_perr;
   assign timeout_cnt    = r_to;
   assign busy           = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder with a stub TX.
// Expected echoes are queued at issue and popped on TX start.
module tb_uart_echo_responder;

   localparam int DEPTH   = 8;
   localparam int ADDR_W  = 3;
   localparam int TIMEOUT = 100;
   localparam int CNT_W   = 8;

   localparam logic [1:0] P_NONE = 2'b00;
   localparam logic [1:0] P_ODD  = 2'b01;
   localparam logic [1:0] P_EVEN = 2'b10;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        parity_type;
   logic [7:0]        rx_data;
   logic              rx_parity_bit;
   logic              rx_recieve_flag;
   logic              tx_sending;
   logic              tx_enable;
   logic [7:0]        tx_din;
   logic [ADDR_W:0]   fifo_count;
   logic [CNT_W-1:0]  overflow_cnt;
   logic [CNT_W-1:0]  parity_err_cnt;
   logic [CNT_W-1:0]  timeout_cnt;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;
   int tx_mode  = 0;
   int hold_cnt = 0;
   int delay_cnt = 0;
   int exp_perr = 0;
   int exp_ovf  = 0;
   int exp_to   = 0;
   logic [7:0] exp_q [$];

   uart_echo_responder #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .parity_type     (parity_type),
      .rx_data         (rx_data),
      .rx_parity_bit   (rx_parity_bit),
      .rx_recieve_flag (rx_recieve_flag),
      .tx_sending      (tx_sending),
      .tx_enable       (tx_enable),
      .tx_din          (tx_din),
      .fifo_count      (fifo_count),
      .overflow_cnt    (overflow_cnt),
      .parity_err_cnt  (parity_err_cnt),
      .timeout_cnt     (timeout_cnt),
      .busy            (busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting", nm);
   endtask

   function automatic int sat(input int v);
      return (v < 255) ? v + 1 : v;
   endfunction

   // Stub TX: 0 normal, 1 never starts, 2 stuck busy
   initial begin
      tx_sending = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_mode == 2) begin
            tx_sending = 1'b1;
            hold_cnt   = 0;
         end else if (tx_mode == 1) begin
            tx_sending = 1'b0;
         end else if (tx_sending) begin
            if (hold_cnt == 0) tx_sending = 1'b0;
            else hold_cnt--;
         end else if (tx_enable) begin
            if (delay_cnt == 0) begin
               tx_sending = 1'b1;
               hold_cnt   = int'($urandom_range(5, 15));
               delay_cnt  = int'($urandom_range(0, 3));
            end else begin
               delay_cnt--;
            end
         end
      end
   end

   // Monitor: every TX start must carry the next expected byte
   initial begin
      logic       prev_s;
      logic       prev_act;
      logic       prev_rst;
      logic [7:0] prev_din;
      logic [7:0] e;
      prev_s   = 1'b0;
      prev_act = 1'b0;
      prev_rst = 1'b0;
      prev_din = '0;
      forever begin
         @(posedge clk);
         #1;
         if (tx_mode == 0 && tx_sending && !prev_s) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL echo_unexpected: got %0h expected none",
                        tx_din);
            end else begin
               e = exp_q.pop_front();
               chk("echo_byte", 32'(tx_din), 32'(e));
            end
         end
         if (reset && prev_rst && prev_act &&
             (tx_enable || tx_sending)) begin
            chk("tx_din_stable", 32'(tx_din), 32'(prev_din));
         end
         prev_s   = tx_sending;
         prev_act = tx_enable | tx_sending;
         prev_rst = reset;
         prev_din = tx_din;
      end
   end

   task automatic send_byte(input logic [7:0] d,
                            input logic [1:0] pt,
                            input bit bad,
                            input int gap);
      int   ones;
      logic pb;
      bit   good;
      ones = $countones(d);
      if (pt == P_ODD) pb = ((ones % 2) == 0);
      else if (pt == P_EVEN) pb = ((ones % 2) == 1);
      else pb = 1'($urandom_range(0, 1));
      good = 1'b1;
      if (bad && (pt == P_ODD || pt == P_EVEN)) begin
         pb   = ~pb;
         good = 1'b0;
      end
      @(negedge clk);
      rx_data         = d;
      rx_parity_bit   = pb;
      parity_type     = pt;
      rx_recieve_flag = 1'b1;
      if (!good) exp_perr = sat(exp_perr);
      else if (exp_q.size() >= DEPTH) exp_ovf = sat(exp_ovf);
      else exp_q.push_back(d);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rx_recieve_flag = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy || tx_sending)
             && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 5000) bound_fail(nm);
   endtask

   task automatic chk_counters(input string nm);
      chk({nm, "_perr"}, 32'(parity_err_cnt), 32'(exp_perr));
      chk({nm, "_ovf"}, 32'(overflow_cnt), 32'(exp_ovf));
      chk({nm, "_to"}, 32'(timeout_cnt), 32'(exp_to));
      chk({nm, "_count"}, 32'(fifo_count), 32'd0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_en"}, 32'(tx_enable), 32'd0);
      chk({nm, "_din"}, 32'(tx_din), 32'd0);
      chk({nm, "_count"}, 32'(fifo_count), 32'd0);
      chk({nm, "_ovf"}, 32'(overflow_cnt), 32'd0);
      chk({nm, "_perr"}, 32'(parity_err_cnt), 32'd0);
      chk({nm, "_to"}, 32'(timeout_cnt), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int cnt;
      int k;
      logic [7:0] b;
      reset           = 1'b0;
      parity_type     = P_ODD;
      rx_data         = '0;
      rx_parity_bit   = 1'b0;
      rx_recieve_flag = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("reset");

      // Single byte: push latency and launch latency
      @(negedge clk);
      rx_data         = 8'hA4;
      parity_type     = P_ODD;
      rx_parity_bit   = 1'b0;
      rx_recieve_flag = 1'b1;
      exp_q.push_back(8'hA4);
      @(posedge clk);
      #1;
      chk("lat_push_count", 32'(fifo_count), 32'd1);
      @(negedge clk);
      rx_recieve_flag = 1'b0;
      @(posedge clk);
      #1;
      chk("lat_en_c1", 32'(tx_enable), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_en_c2", 32'(tx_enable), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_en_c3", 32'(tx_enable), 32'd1);
      chk("lat_din", 32'(tx_din), 32'hA4);
      wait_idle("single_drain");
      chk_counters("single");

      // Wrong parity bit, even parity: dropped
      send_byte(8'h3C, P_EVEN, 1'b1, 10);
      wait_idle("perr_drain");
      chk_counters("perr");

      // Burst with draining in parallel
      for (int i = 0; i < 10; i++) begin
         send_byte(8'(i), P_ODD, 1'b0, 25);
      end
      wait_idle("burst_drain");
      chk_counters("burst");

      // Randomised bytes, parity modes and corruptions
      for (int i = 0; i < 30; i++) begin
         send_byte(8'($urandom), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 4) == 0),
                   int'($urandom_range(28, 40)));
      end
      wait_idle("rand_drain");
      chk_counters("rand");

      // TX stuck busy: FIFO fills, extras overflow
      @(negedge clk);
      tx_mode = 2;
      repeat (2) @(negedge clk);
      k = int'($urandom_range(1, 3));
      for (int i = 0; i < DEPTH + k; i++) begin
         send_byte(8'($urandom), P_ODD, 1'b0, 2);
      end
      @(posedge clk);
      #1;
      chk("full_count", 32'(fifo_count), 32'(DEPTH));
      chk("full_ovf", 32'(overflow_cnt), 32'(exp_ovf));
      chk("full_busy", 32'(busy), 32'd1);
      @(negedge clk);
      tx_mode = 0;
      wait_idle("full_drain");
      chk_counters("full");

      // TX never starts: launch abandoned, then retried
      @(negedge clk);
      tx_mode = 1;
      b = 8'($urandom);
      send_byte(b, P_NONE, 1'b0, 0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!tx_enable && n < 20);
      if (!tx_enable) bound_fail("to_first_launch");
      cnt = 1;
      n = 0;
      while (n < 1000) begin
         @(posedge clk);
         #1;
         n++;
         if (tx_enable) cnt++;
         else break;
      end
      chk("to_enable_len", 32'(cnt), 32'(TIMEOUT));
      exp_to = sat(exp_to);
      chk("to_cnt", 32'(timeout_cnt), 32'(exp_to));
      chk("to_head_kept", 32'(fifo_count), 32'd1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!tx_enable && n < 20);
      if (!tx_enable) bound_fail("to_relaunch");
      chk("to_relaunch_din", 32'(tx_din), 32'(b));
      @(negedge clk);
      tx_mode = 0;
      wait_idle("to_drain");
      chk_counters("to");

      // Reset pulse while a frame is on the wire
      send_byte(8'($urandom), P_ODD, 1'b0, 0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!tx_sending && n < 50);
      if (!tx_sending) bound_fail("rst_wait_sending");
      @(negedge clk);
      reset           = 1'b0;
      rx_data         = 8'h55;
      parity_type     = P_NONE;
      rx_recieve_flag = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      reset    = 1'b1;
      exp_perr = 0;
      exp_ovf  = 0;
      exp_to   = 0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_capture", 32'(fifo_count), 32'd0);
      chk("rst_no_launch", 32'(tx_enable), 32'd0);
      chk("rst_not_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rx_recieve_flag = 1'b0;
      wait_idle("rst_settle");

      // Traffic after reset
      for (int i = 0; i < 6; i++) begin
         send_byte(8'($urandom), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 30);
      end
      wait_idle("post_drain");
      chk_counters("post");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
